// File: rtl/lcd_timing_driver.sv
// LCD panel timing generator: selects a timing table from the panel ID,
// runs the horizontal/vertical counters, and produces the sync, data-enable,
// pixel-request and pixel-coordinate signals for an RGB565 parallel panel.
module lcd_timing_driver #(
  parameter int DATA_W = 16
) (
  input  logic              lcd_clk,
  input  logic              sys_rst_n,
  input  logic [15:0]       lcd_id,
  input  logic [DATA_W-1:0] pixel_data,
  output logic              pixel_req,
  output logic [10:0]       pixel_xpos,
  output logic [10:0]       pixel_ypos,
  output logic [10:0]       h_disp,
  output logic [10:0]       v_disp,
  output logic              lcd_hs,
  output logic              lcd_vs,
  output logic              lcd_de,
  output logic [DATA_W-1:0] lcd_rgb,
  output logic              lcd_bl,
  output logic              lcd_rst
);

  // Front porches are implied by the totals, so only these fields are kept.
  typedef struct packed {
    logic [10:0] hs;
    logic [10:0] hb;
    logic [10:0] hd;
    logic [10:0] ht;
    logic [10:0] vs;
    logic [10:0] vb;
    logic [10:0] vd;
    logic [10:0] vt;
  } tab_t;

  typedef enum logic [1:0] {
    SEL_4342,
    SEL_7084,
    SEL_7016,
    SEL_1018
  } sel_t;

  function automatic sel_t id_sel(input logic [15:0] id);
    sel_t s;
    case (id)
      16'h7084: s = SEL_7084;
      16'h7016: s = SEL_7016;
      16'h1018: s = SEL_1018;
      default:  s = SEL_4342;
    endcase
    return s;
  endfunction

  function automatic tab_t sel_tab(input sel_t s);
    tab_t t;
    case (s)
      SEL_7084: t = '{11'd128, 11'd88,  11'd800,  11'd1056, 11'd2,  11'd33, 11'd480, 11'd525};
      SEL_7016: t = '{11'd20,  11'd140, 11'd1024, 11'd1344, 11'd3,  11'd20, 11'd600, 11'd635};
      SEL_1018: t = '{11'd10,  11'd80,  11'd1280, 11'd1440, 11'd3,  11'd10, 11'd800, 11'd823};
      default:  t = '{11'd41,  11'd2,   11'd480,  11'd525,  11'd10, 11'd2,  11'd272, 11'd286};
    endcase
    return t;
  endfunction

  sel_t        sel_nxt;
  sel_t        sel_p0;
  tab_t        tab_p0;
  logic        tab_chg;
  logic [10:0] h_cnt;
  logic [10:0] v_cnt;
  logic [10:0] h_start;
  logic [10:0] h_end;
  logic [10:0] v_start;
  logic [10:0] v_end;
  logic        reqw;

  assign sel_nxt = id_sel(lcd_id);
  // Counters restart at the same edge the new table is captured.
  assign tab_chg = (sel_nxt != sel_p0);

  // Table register: re-sampled from the panel ID every cycle.
  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sel_p0 <= SEL_4342;
      tab_p0 <= sel_tab(SEL_4342);
    end else begin
      sel_p0 <= sel_nxt;
      tab_p0 <= sel_tab(sel_nxt);
    end
  end

  // Horizontal/vertical raster counters; vertical steps on horizontal wrap.
  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tab_chg) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == tab_p0.ht - 11'd1) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == tab_p0.vt - 11'd1) ? 11'd0 : v_cnt + 11'd1;
    end else begin
      h_cnt <= h_cnt + 11'd1;
    end
  end

  // The request window opens one column early so data arrives with lcd_de.
  assign h_start = tab_p0.hs + tab_p0.hb - 11'd1;
  assign h_end   = h_start + tab_p0.hd - 11'd1;
  assign v_start = tab_p0.vs + tab_p0.vb;
  assign v_end   = v_start + tab_p0.vd - 11'd1;
  assign reqw    = (h_cnt >= h_start) && (h_cnt <= h_end) &&
                   (v_cnt >= v_start) && (v_cnt <= v_end);

  assign pixel_req  = reqw;
  assign pixel_xpos = reqw ? (h_cnt - h_start) : 11'd0;
  assign pixel_ypos = reqw ? (v_cnt - v_start + 11'd1) : 11'd0;
  assign h_disp     = tab_p0.hd;
  assign v_disp     = tab_p0.vd;

  // Panel-side outputs: syncs and data enable lag the counters by one cycle.
  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lcd_hs  <= 1'b1;
      lcd_vs  <= 1'b1;
      lcd_de  <= 1'b0;
      lcd_bl  <= 1'b0;
      lcd_rst <= 1'b0;
    end else begin
      lcd_hs  <= (h_cnt >= tab_p0.hs);
      lcd_vs  <= (v_cnt >= tab_p0.vs);
      lcd_de  <= reqw;
      lcd_bl  <= 1'b1;
      lcd_rst <= 1'b1;
    end
  end

  assign lcd_rgb = lcd_de ? pixel_data : '0;

endmodule

// File: doc/lcd_timing_driver.md
LCD_TIMING_DRIVER -- requirements
Module: lcd_timing_driver

Interface
REQ-001 SHALL have port: lcd_clk  input  1  pixel clock; all logic on rising edge.
REQ-002 SHALL have port: sys_rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: lcd_id  input  16  panel ID; selects the timing table.
REQ-004 SHALL have port: pixel_data  input  16  RGB565 pixel from the display stage, valid in the cycle after pixel_req.
REQ-005 SHALL have port: pixel_req  output  1  pixel request, one cycle ahead of lcd_de.
REQ-006 SHALL have port: pixel_xpos  output  11  active-column index for the requested pixel.
REQ-007 SHALL have port: pixel_ypos  output  11  active-row index for the requested pixel.
REQ-008 SHALL have port: h_disp  output  11  active width of the selected table.
REQ-009 SHALL have port: v_disp  output  11  active height of the selected table.
REQ-010 SHALL have port: lcd_hs  output  1  horizontal sync, active low.
REQ-011 SHALL have port: lcd_vs  output  1  vertical sync, active low.
REQ-012 SHALL have port: lcd_de  output  1  data enable.
REQ-013 SHALL have port: lcd_rgb  output  16  pixel bus to the panel.
REQ-014 SHALL have port: lcd_bl  output  1  backlight enable.
REQ-015 SHALL have port: lcd_rst  output  1  panel reset, active low.

Function
REQ-016 SHALL register a timing table from lcd_id every cycle, as (HS, HB, HD, HF, HT / VS, VB, VD, VF, VT):
- 16'h4342: 41,2,480,2,525 / 10,2,272,2,286
- 16'h7084: 128,88,800,40,1056 / 2,33,480,10,525
- 16'h7016: 20,140,1024,160,1344 / 3,20,600,12,635
- 16'h1018: 10,80,1280,70,1440 / 3,10,800,10,823
- any other ID: the 16'h4342 table.
REQ-017 SHALL drive h_disp and v_disp from the registered table's HD and VD values.
REQ-018 SHALL run h_cnt over 0..HT-1, wrapping to 0.
REQ-019 SHALL increment v_cnt only when h_cnt wraps, over 0..VT-1, wrapping to 0 at the end of the frame.
REQ-020 SHALL clear both counters to 0 on the cycle after the registered table changes; the new frame then starts from h_cnt=v_cnt=0 with no partial-line carry-over.
REQ-021 SHALL define the request window, REQW, as h_cnt in [HS+HB-1, HS+HB+HD-2] AND v_cnt in [VS+VB, VS+VB+VD-1].
REQ-022 SHALL drive pixel_req combinationally equal to REQW.
REQ-023 SHALL, while pixel_req=1, drive pixel_xpos = h_cnt-(HS+HB-1) (range 0..HD-1) and pixel_ypos = v_cnt-(VS+VB)+1 (range 1..VD); both SHALL be 0 when pixel_req=0.
REQ-024 SHALL register lcd_de from REQW, so lcd_de(t+1) = pixel_req(t).
REQ-025 SHALL register lcd_hs as 0 exactly when the previous-cycle h_cnt < HS.
REQ-026 SHALL register lcd_vs as 0 exactly when the previous-cycle v_cnt < VS.
REQ-027 SHALL drive lcd_rgb combinationally as pixel_data when lcd_de=1, else 16'h0000.
REQ-028 SHALL hold lcd_bl=1 and lcd_rst=1 from the first clock edge after reset release.
REQ-029 SHALL use 11-bit unsigned arithmetic throughout, with no counter overflow for any table.

Reset
REQ-030 SHALL, while sys_rst_n=0, asynchronously force: h_cnt=v_cnt=0; lcd_hs=1; lcd_vs=1; lcd_de=0; lcd_bl=0; lcd_rst=0; registered table=16'h4342 (h_disp=480, v_disp=272).
REQ-031 SHALL, while sys_rst_n=0, drive pixel_req=0 and pixel_xpos=pixel_ypos=0.
REQ-032 SHALL, when reset asserts mid-line or mid-frame, abort the frame immediately; the first frame after release SHALL start at h_cnt=v_cnt=0.

Verification
REQ-033 SHALL cover: lcd_id=16'h4342, reset released -> first pixel_req at v_cnt=12, h_cnt=42 with xpos=0, ypos=1; lcd_de first high at h_cnt=43.
REQ-034 SHALL cover: lcd_id=16'h4342, one full line -> pixel_req high for exactly 480 cycles per active line; lcd_hs low for exactly 41 cycles in every 525.
REQ-035 SHALL cover: lcd_id=16'h4342, one full frame -> frame period 150150 cycles; lcd_vs low for exactly 5250 cycles; 272 active lines with last ypos=272 and last xpos=479.
REQ-036 SHALL cover: lcd_id switched 16'h4342 -> 16'h7084 mid-frame -> h_disp=800 and v_disp=480 one cycle later, counters restart from 0, next line period 1056 cycles.
REQ-037 SHALL cover: lcd_id=16'hFFFF -> behaviour identical to 16'h4342.
REQ-038 SHALL cover: pixel_data=16'hF800 held constant -> lcd_rgb=16'hF800 only while lcd_de=1, else 0; reset pulsed mid-frame -> lcd_hs=lcd_vs=1 and lcd_de=0 immediately.
